tile_hit_judge: RTL

//  Game-play judge for the piano-tile game. Owns the beat counter that drives the
//  H_check lookup and consumes its result: h_expect, the cumulative count of notes
//  due by the current beat. Counts correct player key hits against h_expect.

---
 rtl/tile_hit_judge.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/tile_hit_judge.sv
// tile_hit_judge: game-play judge for the piano-tile game.
// Owns the beat counter that addresses the external H_check lookup and
// compares the returned h_expect (notes due by the current beat) against the
// number of correctly hit notes. Lagging play, wrong keys or an unfinished
// chart end the game as LOSE; hitting every note ends it as WIN.
//
// Optional feature macro: WRONG_KEY_PENALTY_EN
//   defined   : a wrong key costs one score point and play continues.
//   undefined : a wrong key ends the game (LOSE).
//
// Interface semantics: start, beat_tick and key_valid are single-cycle
// pulses with no back-pressure; each is acted on in the cycle it is high and
// only in the states that accept it, otherwise it is dropped. All outputs
// are registered (or decoded from registered state) and reflect an input
// pulse one cycle later.
module tile_hit_judge #(
    parameter int BEAT_MAX = 96,
    parameter int NOTE_MAX = 44,
    parameter int LAG_TOL  = 1,
    parameter int LEAD_TOL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       beat_tick,
    input  logic       key_valid,
    input  logic [1:0] key_col,
    input  logic [1:0] note_col,
    input  logic [5:0] h_expect,
    output logic [6:0] beat_cnt,
    output logic [5:0] hit_cnt,
    output logic [7:0] score,
    output logic       playing,
    output logic       win,
    output logic       lose,
    output logic       miss_pulse,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_WIN  = 2'd2;
    localparam logic [1:0] S_LOSE = 2'd3;

    localparam logic [6:0]        BEAT_MAX_W = 7'(BEAT_MAX);
    localparam logic [5:0]        NOTE_MAX_W = 6'(NOTE_MAX);
    localparam logic [6:0]        LEAD_TOL_W = 7'(LEAD_TOL);
    localparam logic signed [6:0] LAG_TOL_S  = 7'(LAG_TOL);

    logic [1:0]        state, state_nxt;
    logic [6:0]        beat_nxt;
    logic [5:0]        hit_nxt;
    logic [7:0]        score_nxt;
    logic              miss_nxt;
    logic              wrong_lose;
    logic              lag_lose;
    logic              end_lose;
    logic signed [6:0] lag;

    // Next-state logic: the key press is resolved first, then the beat
    // boundary is judged on the post-key hit count; WIN outranks LOSE.
    always_comb begin
        state_nxt  = state;
        beat_nxt   = beat_cnt;
        hit_nxt    = hit_cnt;
        score_nxt  = score;
        miss_nxt   = 1'b0;
        wrong_lose = 1'b0;
        lag_lose   = 1'b0;
        end_lose   = 1'b0;
        lag        = '0;

        case (state)
            S_PLAY: begin
                if (key_valid) begin
                    if (key_col == note_col) begin
                        // Accept the hit unless the player is too far ahead.
                        if ({1'b0, hit_cnt} < ({1'b0, h_expect} + LEAD_TOL_W)) begin
                            hit_nxt   = hit_cnt + 6'd1;
                            score_nxt = (score == 8'hff) ? score : score + 8'd1;
                        end else begin
                            miss_nxt = 1'b1;
                        end
                    end else begin
                        miss_nxt = 1'b1;
`ifdef WRONG_KEY_PENALTY_EN
                        score_nxt = (score == 8'h00) ? score : score - 8'd1;
`else
                        wrong_lose = 1'b1;
`endif
                    end
                end

                // Signed difference: a negative value means the player is ahead.
                lag = $signed({1'b0, h_expect}) - $signed({1'b0, hit_nxt});
                if (beat_tick) begin
                    lag_lose = (lag > LAG_TOL_S);
                    end_lose = (beat_cnt == BEAT_MAX_W) && (hit_nxt != NOTE_MAX_W);
                end

                if (hit_nxt == NOTE_MAX_W) begin
                    state_nxt = S_WIN;
                end else if (wrong_lose || lag_lose || end_lose) begin
                    state_nxt = S_LOSE;
                end else if (beat_tick) begin
                    beat_nxt = beat_cnt + 7'd1;
                end
            end
            default: begin
                // IDLE, WIN and LOSE only react to start; counters hold.
                if (start) begin
                    state_nxt = S_PLAY;
                    beat_nxt  = 7'd1;
                    hit_nxt   = 6'd0;
                    score_nxt = 8'd0;
                end
            end
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            beat_cnt   <= 7'd0;
            hit_cnt    <= 6'd0;
            score      <= 8'd0;
            miss_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_nxt;
            hit_cnt    <= hit_nxt;
            score      <= score_nxt;
            miss_pulse <= miss_nxt;
        end
    end

    // Status flags decoded from the registered state.
    always_comb begin
        playing   = (state == S_PLAY);
        win       = (state == S_WIN);
        lose      = (state == S_LOSE);
        state_dbg = state;
    end

endmodule
